// File: rtl/mem_write_checker.sv
// mem_write_checker -- watches the CPU data-port store stream during a test
// program and produces a sticky verdict.
//
// A start pulse arms monitoring (RUN). Stores to SCRATCH_ADDR are counted;
// a store to PASS_ADDR ends the run with pass (correct data and enough
// scratch stores) or fail. Any other store address fails. If no verdict
// store arrives within MAX_CYCLES RUN cycles, the run times out.
//
// Ports:
//   clk, rst (async, active-low)         clock / reset
//   start                                arm or re-arm (clears everything)
//   memwrite, dataadr, writedata         store strobe, address, data
//   done, pass, fail, timeout            registered sticky verdict flags
//   store_cnt                            stores accepted in RUN (saturating)
//   cycle_cnt                            RUN cycles elapsed
//   err_addr, err_data                   offending store on fail, else 0
//
// Optional store log, enabled by defining MEM_WRITE_CHECKER_LOG_EN:
//   log_pop                              drop the head entry
//   log_empty, log_full                  occupancy status
//   log_addr, log_data                   head entry (combinational)
module mem_write_checker #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 32,
  parameter int unsigned PASS_ADDR    = 84,
  parameter int unsigned PASS_DATA    = 7,
  parameter int unsigned SCRATCH_ADDR = 80,
  parameter int unsigned MIN_SCRATCH  = 0,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter int unsigned LOG_DEPTH    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [15:0]   store_cnt,
  output logic [31:0]   cycle_cnt,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_data
`ifdef MEM_WRITE_CHECKER_LOG_EN
  ,
  input  logic          log_pop,
  output logic          log_empty,
  output logic          log_full,
  output logic [AW-1:0] log_addr,
  output logic [DW-1:0] log_data
`endif
);

  localparam logic [AW-1:0] PASS_A = AW'(PASS_ADDR);
  localparam logic [AW-1:0] SCR_A  = AW'(SCRATCH_ADDR);
  localparam logic [DW-1:0] PASS_D = DW'(PASS_DATA);
  localparam logic [31:0]   LAST_CYCLE = 32'(MAX_CYCLES - 1);

  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_log_depth
    $error("LOG_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t      state, state_nxt;
  logic [15:0] scr_cnt;
  logic        is_store;
  logic        hit_pass, hit_scr, data_ok, scr_ok, at_limit;

  assign hit_pass = (dataadr == PASS_A);
  assign hit_scr  = (dataadr == SCR_A);
  assign data_ok  = (writedata == PASS_D);
  assign scr_ok   = (32'(scr_cnt) >= MIN_SCRATCH);
  assign at_limit = (cycle_cnt == LAST_CYCLE);

  // A verdict store in the last budget cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    is_store  = 1'b0;
    case (state)
      S_RUN: begin
        if (!start) begin
          is_store = memwrite;
          if (memwrite && hit_pass)
            state_nxt = (data_ok && scr_ok) ? S_PASS : S_FAIL;
          else if (memwrite && !hit_scr)
            state_nxt = S_FAIL;
          else if (at_limit)
            state_nxt = S_TOUT;
        end
      end
      default: if (start) state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_cnt <= '0;
      cycle_cnt <= '0;
      scr_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (start) begin
      store_cnt <= '0;
      cycle_cnt <= '0;
      scr_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (state == S_RUN) begin
      if (is_store && store_cnt != '1)
        store_cnt <= store_cnt + 16'd1;
      if (is_store && hit_scr && !hit_pass && scr_cnt != '1)
        scr_cnt <= scr_cnt + 16'd1;
      // The cycle that leaves RUN is not counted, so a timeout holds MAX_CYCLES-1.
      if (state_nxt == S_RUN)
        cycle_cnt <= cycle_cnt + 32'd1;
      pass    <= (state_nxt == S_PASS);
      fail    <= (state_nxt == S_FAIL);
      timeout <= (state_nxt == S_TOUT);
      done    <= (state_nxt != S_RUN);
      if (state_nxt == S_FAIL) begin
        err_addr <= dataadr;
        err_data <= writedata;
      end
    end
  end

`ifdef MEM_WRITE_CHECKER_LOG_EN
  localparam int unsigned PW = $clog2(LOG_DEPTH);

  logic [AW+DW-1:0] log_mem [LOG_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      log_cnt;
  logic             do_pop;

  assign log_empty = (log_cnt == '0);
  assign log_full  = (log_cnt == (PW+1)'(LOG_DEPTH));
  assign do_pop    = log_pop && !log_empty;
  assign log_addr  = log_mem[rd_ptr][AW+DW-1:DW];
  assign log_data  = log_mem[rd_ptr][DW-1:0];

  always_ff @(posedge clk) begin
    if (is_store) log_mem[wr_ptr] <= {dataadr, writedata};
  end

  // Full + push drops the oldest entry; that and a real pop both advance
  // the read pointer once, so occupancy only moves on unpaired push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      log_cnt <= '0;
    end else if (start) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      log_cnt <= '0;
    end else begin
      if (is_store) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || (is_store && log_full)) rd_ptr <= rd_ptr + 1'b1;
      if (is_store && !do_pop && !log_full) log_cnt <= log_cnt + 1'b1;
      else if (do_pop && !is_store)         log_cnt <= log_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two instances (MIN_SCRATCH 0 and 2, both with
// a 50-cycle budget and a 4-entry log) share one directed stimulus stream.
// A queue-based model predicts every output; literal checks pin key points.
module tb_mem_write_checker;

  localparam int unsigned MAXC = 50;
  localparam int unsigned LOGD = 4;
  localparam int unsigned M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, memwrite = 1'b0, log_pop = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;

  logic        a_done, a_pass, a_fail, a_tout;
  logic [15:0] a_sc;
  logic [31:0] a_cc, a_ea, a_ed;
  logic        b_done, b_pass, b_fail, b_tout;
  logic [15:0] b_sc;
  logic [31:0] b_cc, b_ea, b_ed;
`ifdef MEM_WRITE_CHECKER_LOG_EN
  logic        a_lempty, a_lfull, b_lempty, b_lfull;
  logic [31:0] a_laddr, a_ldata, b_laddr, b_ldata;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.DW(32), .AW(32), .MIN_SCRATCH(0), .MAX_CYCLES(MAXC), .LOG_DEPTH(LOGD)) dut_a (
    .clk(clk), .rst(rst), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tout),
    .store_cnt(a_sc), .cycle_cnt(a_cc), .err_addr(a_ea), .err_data(a_ed)
`ifdef MEM_WRITE_CHECKER_LOG_EN
    , .log_pop(log_pop), .log_empty(a_lempty), .log_full(a_lfull),
    .log_addr(a_laddr), .log_data(a_ldata)
`endif
  );

  mem_write_checker #(.DW(32), .AW(32), .MIN_SCRATCH(2), .MAX_CYCLES(MAXC), .LOG_DEPTH(LOGD)) dut_b (
    .clk(clk), .rst(rst), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tout),
    .store_cnt(b_sc), .cycle_cnt(b_cc), .err_addr(b_ea), .err_data(b_ed)
`ifdef MEM_WRITE_CHECKER_LOG_EN
    , .log_pop(log_pop), .log_empty(b_lempty), .log_full(b_lfull),
    .log_addr(b_laddr), .log_data(b_ldata)
`endif
  );

  // ---------------- model ----------------
  typedef struct packed {
    int unsigned mode;
    int unsigned stores;
    int unsigned scratch;
    int unsigned cycles;
    logic [31:0] ea;
    logic [31:0] ed;
  } mdl_t;

  mdl_t ma = '0, mb = '0;
  logic [63:0] qa[$], qb[$];

  task automatic mstep(inout mdl_t m, input int unsigned min_scr);
    bit verdict;
    verdict = 1'b0;
    if (start) begin
      m = '0;
      m.mode = M_RUN;
    end else if (m.mode == M_RUN) begin
      if (memwrite) begin
        if (m.stores < 65535) m.stores++;
        if (dataadr == 84) begin
          verdict = 1'b1;
          if (writedata == 7 && m.scratch >= min_scr) m.mode = M_PASS;
          else begin m.mode = M_FAIL; m.ea = dataadr; m.ed = writedata; end
        end else if (dataadr == 80) begin
          if (m.scratch < 65535) m.scratch++;
        end else begin
          verdict = 1'b1;
          m.mode = M_FAIL; m.ea = dataadr; m.ed = writedata;
        end
      end
      if (!verdict) begin
        if (m.cycles == MAXC - 1) m.mode = M_TOUT;
        else m.cycles++;
      end
    end
  endtask

  task automatic lstep(inout logic [63:0] q[$], input int unsigned mode_before);
    logic [63:0] tmp;
    if (start) q.delete();
    else begin
      if (log_pop && q.size() > 0) tmp = q.pop_front();
      if (mode_before == M_RUN && memwrite) begin
        q.push_back({dataadr, writedata});
        if (q.size() > LOGD) tmp = q.pop_front();
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        ma = '0; mb = '0; qa.delete(); qb.delete();
      end else begin
        lstep(qa, ma.mode);
        lstep(qb, mb.mode);
        mstep(ma, 0);
        mstep(mb, 2);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input logic dn, ps, fl, to,
                          input logic [15:0] sc, input logic [31:0] cc, ea, ed);
    chk({tag, ".pass"}, 64'(ps), 64'(m.mode == M_PASS));
    chk({tag, ".fail"}, 64'(fl), 64'(m.mode == M_FAIL));
    chk({tag, ".timeout"}, 64'(to), 64'(m.mode == M_TOUT));
    chk({tag, ".done"}, 64'(dn), 64'(m.mode >= M_PASS));
    chk({tag, ".store_cnt"}, 64'(sc), 64'(m.stores));
    chk({tag, ".cycle_cnt"}, 64'(cc), 64'(m.cycles));
    chk({tag, ".err_addr"}, 64'(ea), 64'(m.ea));
    chk({tag, ".err_data"}, 64'(ed), 64'(m.ed));
  endtask

  always @(negedge clk) begin
    cmp_inst("a", ma, a_done, a_pass, a_fail, a_tout, a_sc, a_cc, a_ea, a_ed);
    cmp_inst("b", mb, b_done, b_pass, b_fail, b_tout, b_sc, b_cc, b_ea, b_ed);
`ifdef MEM_WRITE_CHECKER_LOG_EN
    chk("a.log_empty", 64'(a_lempty), 64'(qa.size() == 0));
    chk("a.log_full", 64'(a_lfull), 64'(qa.size() == LOGD));
    if (qa.size() > 0) chk("a.log_head", {a_laddr, a_ldata}, qa[0]);
    chk("b.log_empty", 64'(b_lempty), 64'(qb.size() == 0));
    chk("b.log_full", 64'(b_lfull), 64'(qb.size() == LOGD));
    if (qb.size() > 0) chk("b.log_head", {b_laddr, b_ldata}, qb[0]);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit st, input bit mw, input logic [31:0] a, input logic [31:0] d,
                     input bit pp);
    start = st; memwrite = mw; dataadr = a; writedata = d; log_pop = pp;
    @(posedge clk);
    #1;
    start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; log_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk("reset.done", 64'(a_done), 0);
    chk("reset.store_cnt", 64'(a_sc), 0);
    chk("reset.cycle_cnt", 64'(a_cc), 0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    // stores into memory are ignored while idle
    cyc(0, 1, 88, 1, 0);
    chk("idle_ignore.fail", 64'(a_fail), 0);
    chk("idle_ignore.store_cnt", 64'(a_sc), 0);

    // two scratch stores then passing store
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 80, 5, 0);
    cyc(0, 1, 80, 9, 0);
    chk("pass3.pass_early", 64'(a_pass), 0);
    cyc(0, 1, 84, 7, 0);
    chk("pass3.pass", 64'(a_pass), 1);
    chk("pass3.done", 64'(a_done), 1);
    chk("pass3.fail", 64'(a_fail), 0);
    chk("pass3.store_cnt", 64'(a_sc), 3);
    chk("pass3.b_pass", 64'(b_pass), 1);

    // wrong data at the pass address
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 84, 6, 0);
    chk("baddata.fail", 64'(a_fail), 1);
    chk("baddata.err_addr", 64'(a_ea), 84);
    chk("baddata.err_data", 64'(a_ed), 6);

    // stray address, later stores have no effect; start clears err capture
    cyc(1, 0, 0, 0, 0);
    chk("rearm.err_addr", 64'(a_ea), 0);
    chk("rearm.fail", 64'(a_fail), 0);
    cyc(0, 1, 88, 7, 0);
    chk("stray.fail", 64'(a_fail), 1);
    chk("stray.err_addr", 64'(a_ea), 88);
    cyc(0, 1, 84, 7, 0);
    chk("stray.fail_held", 64'(a_fail), 1);
    chk("stray.pass_held", 64'(a_pass), 0);
    chk("stray.store_cnt_held", 64'(a_sc), 1);

    // timeout boundary
    cyc(1, 0, 0, 0, 0);
    idle(49);
    chk("tout.before", 64'(a_tout), 0);
    chk("tout.cycle_before", 64'(a_cc), 49);
    idle(1);
    chk("tout.timeout", 64'(a_tout), 1);
    chk("tout.done", 64'(a_done), 1);
    chk("tout.cycle_cnt", 64'(a_cc), 49);

    // verdict store in the last budget cycle wins
    cyc(1, 0, 0, 0, 0);
    idle(49);
    cyc(0, 1, 84, 7, 0);
    chk("edge.pass", 64'(a_pass), 1);
    chk("edge.timeout", 64'(a_tout), 0);
    chk("edge.b_fail", 64'(b_fail), 1);
    chk("edge.b_err_data", 64'(b_ed), 7);

    // insufficient scratch stores on MIN_SCRATCH=2 instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 80, 1, 0);
    cyc(0, 1, 84, 7, 0);
    chk("minscr.b_fail", 64'(b_fail), 1);
    chk("minscr.b_err_addr", 64'(b_ea), 84);
    chk("minscr.a_pass", 64'(a_pass), 1);

    // restart while running; the store in the start cycle is dropped
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 80, 1, 0);
    cyc(0, 1, 80, 1, 0);
    cyc(1, 1, 88, 0, 0);
    chk("restart.store_cnt", 64'(a_sc), 0);
    chk("restart.cycle_cnt", 64'(a_cc), 0);
    chk("restart.fail", 64'(a_fail), 0);
    cyc(0, 1, 84, 7, 0);
    chk("restart.pass", 64'(a_pass), 1);
    chk("restart.store_cnt1", 64'(a_sc), 1);

    // asynchronous reset mid-run
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 80, 1, 0);
    cyc(0, 1, 80, 2, 0);
    chk("midrst.store_cnt_before", 64'(a_sc), 2);
    #2 rst = 1'b0;
    #1;
    chk("midrst.store_cnt", 64'(a_sc), 0);
    chk("midrst.cycle_cnt", 64'(a_cc), 0);
    chk("midrst.flags", 64'({a_done, a_pass, a_fail, a_tout}), 0);
    chk("midrst.err", 64'({a_ea, a_ed}), 0);
    @(posedge clk); #3 rst = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 84, 7, 0);
    chk("postrst.pass", 64'(a_pass), 1);
    chk("postrst.store_cnt", 64'(a_sc), 1);

`ifdef MEM_WRITE_CHECKER_LOG_EN
    // log overwrite, pops, pop-while-empty with a push
    cyc(1, 0, 0, 0, 0);
    chk("log.cleared", 64'(a_lempty), 1);
    for (int k = 1; k <= 6; k++) cyc(0, 1, 80, k, 0);
    chk("log.full", 64'(a_lfull), 1);
    for (int k = 3; k <= 6; k++) begin
      chk("log.head_data", 64'(a_ldata), 64'(k));
      chk("log.head_addr", 64'(a_laddr), 80);
      cyc(0, 0, 0, 0, 1);
    end
    chk("log.empty", 64'(a_lempty), 1);
    chk("log.not_full", 64'(a_lfull), 0);
    cyc(0, 1, 80, 9, 1);
    chk("log.pushpop_empty", 64'(a_lempty), 0);
    chk("log.pushpop_data", 64'(a_ldata), 9);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the data bus width.
REQ-002 SHALL have parameter AW, default 32, meaning the address bus width.
REQ-003 SHALL have parameter PASS_ADDR, default 84, meaning the address of the terminating store.
REQ-004 SHALL have parameter PASS_DATA, default 7, meaning the data value of a passing terminating store.
REQ-005 SHALL have parameter SCRATCH_ADDR, default 80, meaning the only non-terminating address a store may target.
REQ-006 SHALL have parameter MIN_SCRATCH, default 0, meaning the scratch stores required before a pass is allowed.
REQ-007 SHALL have parameter MAX_CYCLES, default 10000, meaning the RUN-state cycle budget before timeout.
REQ-008 SHALL have parameter LOG_DEPTH, default 8 (power of two), meaning the store-log FIFO depth.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-011 SHALL have port start, input, 1 bit: a 1-cycle pulse that arms monitoring.
REQ-012 SHALL have port memwrite, input, 1 bit: the store strobe from the CPU data port.
REQ-013 SHALL have port dataadr, input, AW bits: the store address.
REQ-014 SHALL have port writedata, input, DW bits: the store data.
REQ-015 SHALL have ports done, pass, fail and timeout, each an output of 1 bit: sticky verdict flags.
REQ-016 SHALL have port store_cnt, output, 16 bits: stores accepted in RUN, saturating.
REQ-017 SHALL have port cycle_cnt, output, 32 bits: cycles spent in RUN.
REQ-018 SHALL have port err_addr, output, AW bits, and port err_data, output, DW bits: the offending store on fail.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, PASS, FAIL and TOUT, with reset state IDLE.
REQ-020 SHALL go from IDLE to RUN on start, clearing store_cnt, cycle_cnt and the scratch counter; IDLE SHALL ignore memwrite.
REQ-021 SHALL sample a store in RUN at posedge with memwrite=1, one store per cycle.
REQ-022 SHALL go to PASS on a store with dataadr==PASS_ADDR, writedata==PASS_DATA and scratch count >= MIN_SCRATCH.
REQ-023 SHALL go to FAIL on a store to PASS_ADDR with wrong data, or with insufficient scratch stores.
REQ-024 SHALL go to FAIL on a store to any address other than PASS_ADDR or SCRATCH_ADDR.
REQ-025 SHALL count a store to SCRATCH_ADDR (saturating at 2^16-1) and remain in RUN.
REQ-026 SHALL go to TOUT when cycle_cnt reaches MAX_CYCLES-1 with no verdict store; a verdict store in that same cycle SHALL take priority.
REQ-027 SHALL make verdict flags register outputs, asserted the cycle after the deciding store (latency 1); done=pass|fail|timeout.
REQ-028 SHALL capture err_addr/err_data only on transition to FAIL; they SHALL hold zero otherwise.
REQ-029 SHALL hold PASS/FAIL/TOUT until start, which SHALL re-arm to RUN with all counters and flags cleared.
REQ-030 SHALL treat start asserted while in RUN as a restart: counters cleared, any store in that cycle ignored.
REQ-031 SHALL count the verdict store in store_cnt; stores after a verdict SHALL not change any output.

Reset
REQ-032 SHALL, on rst low, asynchronously force state IDLE, all flags 0, store_cnt 0, cycle_cnt 0, err_addr/err_data 0, and the log empty.
REQ-033 SHALL abandon any run on reset mid-RUN, with no verdict produced.

Configuration
REQ-034 SHALL compile in, under macro MEM_WRITE_CHECKER_LOG_EN, a LOG_DEPTH-entry FIFO of {dataadr, writedata} for every RUN store, with ports log_pop (input, 1 bit), log_empty (output, 1 bit), log_full (output, 1 bit), log_addr (output, AW bits) and log_data (output, DW bits).
REQ-035 SHALL, when the log is full, overwrite the oldest entry on a new store (read pointer advances), with the head shown combinationally.
REQ-036 SHALL ignore log_pop when the log is empty; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-037 SHALL clear the log on start.
REQ-038 SHALL, without MEM_WRITE_CHECKER_LOG_EN, omit the log ports and logic entirely and leave all other behaviour identical.

Verification
REQ-039 SHALL pass this check: start, stores (80,5), (80,9), (84,7) -> pass=1 and done=1 one cycle after the third store, fail=0, store_cnt=3.
REQ-040 SHALL pass this check: start, store (84,6) -> fail=1, err_addr=84, err_data=6.
REQ-041 SHALL pass this check: start, store (88,7) -> fail=1, err_addr=88; a later (84,7) leaves the flags unchanged.
REQ-042 SHALL pass this check: with MAX_CYCLES=50 and no stores -> timeout=1 after 50 RUN cycles, cycle_cnt=49; with MIN_SCRATCH=2, start, (80,1), (84,7) -> fail=1.
REQ-043 SHALL pass this check: rst low mid-RUN after 2 stores -> all outputs 0 immediately (asynchronously), then start, (84,7) -> pass=1, store_cnt=1.
REQ-044 SHALL pass this check: with the log enabled and LOG_DEPTH=4, 6 scratch stores with data 1..6 -> log_full=1, and pops return data 3,4,5,6, then log_empty=1.
